// File: rtl/pin_bank_ctrl_if.sv
// pin_bank_ctrl_if: register bus between the bus decoder (master) and pin_bank_ctrl (slave)
//   addr     register address
//   wr_en    one-cycle write strobe, data_in carries the write data
//   rd_en    one-cycle read strobe
//   data_out registered read data, held until the next read
//   rd_valid high exactly one cycle after rd_en
interface pin_bank_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 21
);
   logic [ADDR_W-1:0] addr;
   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid;
   modport master (output addr, wr_en, rd_en, data_in, input data_out, rd_valid);
   modport slave (input addr, wr_en, rd_en, data_in, output data_out, rd_valid);
endinterface

// File: rtl/pin_bank_ctrl.sv
// pin_bank_ctrl: NUM_PINS channels, each off / PWM / constant driver / input sampler
//   clk, reset  clock, synchronous active-high reset
//   bus         register bus slave (GLOBAL at GLOBAL_ADDR, channel c at BASE_ADDR+8*c..+7)
//   pin_out_o   per-pin drive value
//   pin_oe_o    per-pin output enable, 1 = drive
//   pin_in_i    per-pin asynchronous pad input
module pin_bank_ctrl #(
   parameter int NUM_PINS    = 8,
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 21,
   parameter int GLOBAL_ADDR = 0,
   parameter int BASE_ADDR   = 1
) (
   input  logic                clk,
   input  logic                reset,
   pin_bank_ctrl_if.slave      bus,
   output logic [NUM_PINS-1:0] pin_out_o,
   output logic [NUM_PINS-1:0] pin_oe_o,
   input  logic [NUM_PINS-1:0] pin_in_i
);
   localparam int CW = NUM_PINS > 1 ? $clog2(NUM_PINS) : 1;
   localparam int BW = $clog2(DATA_W);
   typedef enum logic [1:0] {IDLE, HIGH, LOW, SAMP} state_t;
   logic [ADDR_W-1:0]      off;
   logic                   glob_hit, ch_hit, start, stop;
   logic [CW-1:0]          ch_idx;
   logic [2:0]             reg_idx;
   logic [NUM_PINS-1:0]    sync1_q, sync2_q;
   logic [7:0][DATA_W-1:0] ch_rd [NUM_PINS];
   logic [DATA_W-1:0]      data_out_q, data_out_d;
   logic                   rd_valid_q;

   assign off        = bus.addr - ADDR_W'(BASE_ADDR);
   assign glob_hit   = bus.addr == ADDR_W'(GLOBAL_ADDR);
   assign ch_hit     = bus.addr >= ADDR_W'(BASE_ADDR) && off < ADDR_W'(8 * NUM_PINS);
   assign ch_idx     = off[CW+2:3];
   assign reg_idx    = off[2:0];
   // STOP wins when both command bits are set
   assign start      = bus.wr_en && glob_hit && bus.data_in[0] && !bus.data_in[1];
   assign stop       = bus.wr_en && glob_hit && bus.data_in[1];
   assign data_out_d = ch_hit ? ch_rd[ch_idx][reg_idx] : '0;
   assign bus.data_out = data_out_q;
   assign bus.rd_valid = rd_valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         sync1_q    <= pin_in_i;
         sync2_q    <= sync1_q;
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) data_out_q <= data_out_d;
      end
   end

   for (genvar c = 0; c < NUM_PINS; c++) begin : g_ch
      logic [2:0]        ctrl_q;
      logic [1:0]        mode;
      logic [DATA_W-1:0] duty_q, anti_q, cyc_q, rate_q;
      logic [DATA_W-1:0] phase_q, phase_d, cnt_q, cnt_d, rcnt_q, rcnt_d;
      logic [DATA_W-1:0] shift_q, shift_d, samples_q, samples_d;
      logic [DATA_W-1:0] cnt_inc, rl_ph, shifted;
      logic [BW-1:0]     bit_q, bit_d;
      state_t            st_q, st_d, rl_st;
      logic              valid_q, valid_d, ovf_q, ovf_d;
      logic              wr, rd, wr_ctrl, rd_stat, rd_samp;
      logic              done, ph_end, sample, complete, busy, pout, poe;

      assign wr       = bus.wr_en && ch_hit && ch_idx == CW'(c);
      assign rd       = bus.rd_en && ch_hit && ch_idx == CW'(c);
      assign wr_ctrl  = wr && reg_idx == 3'd0;
      assign rd_stat  = rd && reg_idx == 3'd5;
      assign rd_samp  = rd && reg_idx == 3'd6;
      assign mode     = ctrl_q[1:0];
      assign busy     = st_q != IDLE;
      assign cnt_inc  = cnt_q + DATA_W'(1);
      assign done     = cyc_q != '0 && cnt_inc == cyc_q;
      assign ph_end   = phase_q == DATA_W'(1);
      // phase to (re)load from the current DUTY/ANTI: HIGH first, LOW if DUTY is 0
      assign rl_st    = duty_q != '0 ? HIGH : anti_q != '0 ? LOW : IDLE;
      assign rl_ph    = duty_q != '0 ? duty_q : anti_q;
      assign sample   = st_q == SAMP && rcnt_q == '0;
      assign complete = sample && bit_q == BW'(DATA_W - 1);
      assign shifted  = {shift_q[DATA_W-2:0], sync2_q[c]};
      assign ch_rd[c] = {{DATA_W{1'b0}}, samples_q, DATA_W'({ovf_q, valid_q, busy}),
                         rate_q, cyc_q, anti_q, duty_q, DATA_W'(ctrl_q)};
      assign pin_out_o[c] = pout;
      assign pin_oe_o[c]  = poe;

      always_ff @(posedge clk) begin
         if (reset) begin
            ctrl_q <= '0;
            duty_q <= '0;
            anti_q <= '0;
            cyc_q  <= '0;
            rate_q <= '0;
         end else if (wr) begin
            if (reg_idx == 3'd0) ctrl_q <= bus.data_in[2:0];
            if (reg_idx == 3'd1) duty_q <= bus.data_in;
            if (reg_idx == 3'd2) anti_q <= bus.data_in;
            if (reg_idx == 3'd3) cyc_q <= bus.data_in;
            if (reg_idx == 3'd4) rate_q <= bus.data_in;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            st_q      <= IDLE;
            phase_q   <= '0;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            samples_q <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
         end else begin
            st_q      <= st_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            samples_q <= samples_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
         end
      end

      always_comb begin
         st_d      = st_q;
         phase_d   = phase_q;
         cnt_d     = cnt_q;
         rcnt_d    = rcnt_q;
         bit_d     = bit_q;
         shift_d   = shift_q;
         samples_d = complete ? shifted : samples_q;
         // a SAMPLES read in the completion cycle returns the old word; the new one stays valid
         valid_d   = (valid_q && !rd_samp) || complete;
         ovf_d     = (ovf_q && !rd_stat) || (complete && valid_q && !rd_samp);
         if (wr_ctrl || stop) begin
            st_d    = IDLE;
            phase_d = '0;
            cnt_d   = '0;
            rcnt_d  = '0;
            bit_d   = '0;
         end else begin
            case (st_q)
               IDLE: begin
                  if (start && mode == 2'd1) begin
                     st_d    = rl_st;
                     phase_d = rl_ph;
                     cnt_d   = '0;
                  end else if (start && mode == 2'd3) begin
                     st_d   = SAMP;
                     rcnt_d = '0;
                     bit_d  = '0;
                  end
               end
               HIGH: begin
                  if (!ph_end) phase_d = phase_q - DATA_W'(1);
                  else if (anti_q != '0) begin
                     st_d    = LOW;
                     phase_d = anti_q;
                  end else begin
                     cnt_d   = cnt_inc;
                     st_d    = done ? IDLE : rl_st;
                     phase_d = rl_ph;
                  end
               end
               LOW: begin
                  if (!ph_end) phase_d = phase_q - DATA_W'(1);
                  else begin
                     cnt_d   = cnt_inc;
                     st_d    = done ? IDLE : rl_st;
                     phase_d = rl_ph;
                  end
               end
               default: begin
                  if (sample) begin
                     shift_d = shifted;
                     bit_d   = complete ? '0 : bit_q + BW'(1);
                     rcnt_d  = rate_q;
                  end else rcnt_d = rcnt_q - DATA_W'(1);
               end
            endcase
         end
      end

      always_comb begin
         pout = mode == 2'd2 ? ctrl_q[2] : st_q == HIGH;
         poe  = mode == 2'd1 || mode == 2'd2;
      end
   end
endmodule

// File: tb/tb_pin_bank_ctrl.sv
// tb_pin_bank_ctrl: directed self-checking bench for pin_bank_ctrl
module tb_pin_bank_ctrl;
   localparam int NP = 8;
   localparam int DW = 16;
   localparam int AW = 21;
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NP-1:0] pin_out, pin_oe;
   logic [NP-1:0] pin_in = '0;
   logic [DW-1:0] d;
   logic [DW-1:0] word = 16'hA5C3;
   logic [10:0]   pat2 = 11'b00011100111;
   logic [8:0]    pat3 = 9'b001111011;
   int            checks = 0;
   int            errors = 0;

   pin_bank_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   pin_bank_ctrl #(.NUM_PINS(NP), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .pin_out_o (pin_out),
      .pin_oe_o  (pin_oe),
      .pin_in_i  (pin_in)
   );

   always #5 clk = ~clk;

   function automatic logic [AW-1:0] ra(input int ch, input int r);
      return AW'(1 + 8 * ch + r);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
      bus.addr = a;
      bus.data_in = v;
      bus.wr_en = 1'b1;
      tick;
      bus.wr_en = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] v);
      bus.addr = a;
      bus.rd_en = 1'b1;
      tick;
      bus.rd_en = 1'b0;
      check("rd_valid", 32'(bus.rd_valid), 32'd1);
      v = bus.data_out;
   endtask

   task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      logic [DW-1:0] v;
      rd(a, v);
      check(tag, 32'(v), 32'(exp));
   endtask

   initial begin
      bus.addr = '0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.data_in = '0;
      repeat (3) tick;
      reset = 1'b0;
      check("rst_oe", 32'(pin_oe), 32'd0);
      check("rst_out", 32'(pin_out), 32'd0);
      check("rst_rdv", 32'(bus.rd_valid), 32'd0);
      check("rst_dout", 32'(bus.data_out), 32'd0);
      for (int r = 0; r < 8; r++) rd_chk("rst_ch0", ra(0, r), '0);
      for (int r = 0; r < 8; r++) rd_chk("rst_ch7", ra(7, r), '0);
      tick;
      check("rdv_drop", 32'(bus.rd_valid), 32'd0);
      wr(ra(0, 5), 16'hFFFF);
      wr(ra(0, 6), 16'hFFFF);
      wr(ra(0, 7), 16'hFFFF);
      wr(AW'(65), 16'hFFFF);
      rd_chk("ro_status", ra(0, 5), '0);
      rd_chk("ro_samples", ra(0, 6), '0);
      rd_chk("reserved", ra(0, 7), '0);
      rd_chk("unmapped", AW'(65), '0);
      rd_chk("global_rd", AW'(0), '0);
      wr(ra(0, 1), 16'h1234);
      rd_chk("duty_rw", ra(0, 1), 16'h1234);
      tick;
      check("dout_hold", 32'(bus.data_out), 32'h1234);
      // ch2: PWM 3 high / 2 low, two cycles
      wr(ra(2, 1), 16'd3);
      wr(ra(2, 2), 16'd2);
      wr(ra(2, 3), 16'd2);
      wr(ra(2, 0), 16'd1);
      check("pwm2_oe", 32'(pin_oe), 32'h04);
      wr(AW'(0), 16'd1);
      for (int i = 0; i < 11; i++) begin
         check("pwm2_pin", 32'(pin_out[2]), 32'(pat2[i]));
         check("pwm2_others", 32'(pin_out & 8'hFB), 32'd0);
         if (i == 9) rd_chk("pwm2_busy", ra(2, 5), 16'd1);
         else if (i < 10) tick;
      end
      rd_chk("pwm2_idle", ra(2, 5), 16'd0);
      wr(ra(2, 0), 16'd0);
      check("pwm2_off_oe", 32'(pin_oe), 32'd0);
      // ch0: infinite square wave, then STOP
      wr(ra(0, 1), 16'd1);
      wr(ra(0, 2), 16'd1);
      wr(ra(0, 0), 16'd1);
      wr(AW'(0), 16'd1);
      for (int i = 0; i < 7; i++) begin
         check("sq0_pin", 32'(pin_out[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
         tick;
      end
      wr(AW'(0), 16'd2);
      check("sq0_stop_pin", 32'(pin_out[0]), 32'd0);
      rd_chk("sq0_stop_busy", ra(0, 5), 16'd0);
      wr(AW'(0), 16'd3);
      check("sq0_both_pin", 32'(pin_out[0]), 32'd0);
      tick;
      check("sq0_both_pin2", 32'(pin_out[0]), 32'd0);
      rd_chk("sq0_both_busy", ra(0, 5), 16'd0);
      wr(ra(0, 0), 16'd0);
      // ch3: constant driver, then mid-HIGH DUTY change
      wr(ra(3, 0), 16'd6);
      check("const3_out", 32'(pin_out[3]), 32'd1);
      check("const3_oe", 32'(pin_oe[3]), 32'd1);
      wr(ra(3, 0), 16'd0);
      check("off3_oe", 32'(pin_oe[3]), 32'd0);
      check("off3_out", 32'(pin_out[3]), 32'd0);
      wr(ra(3, 1), 16'd2);
      wr(ra(3, 2), 16'd1);
      wr(ra(3, 3), 16'd2);
      wr(ra(3, 0), 16'd1);
      wr(AW'(0), 16'd1);
      for (int i = 0; i < 9; i++) begin
         check("duty3_pin", 32'(pin_out[3]), 32'(pat3[i]));
         if (i == 0) wr(ra(3, 1), 16'd4);
         else tick;
      end
      wr(ra(3, 0), 16'd0);
      // ch1: input sampler, RATE=0, word 0xA5C3 MSB first
      wr(ra(1, 0), 16'd3);
      fork
         begin
            for (int k = 0; k < 16; k++) begin
               pin_in[1] = word[15-k];
               tick;
            end
         end
         begin
            tick;
            wr(AW'(0), 16'd1);
         end
      join
      repeat (2) tick;
      rd_chk("in1_status", ra(1, 5), 16'd3);
      rd_chk("in1_samples", ra(1, 6), 16'hA5C3);
      rd_chk("in1_valid_clr", ra(1, 5), 16'd1);
      wr(AW'(0), 16'd2);
      rd_chk("in1_stop", ra(1, 5), 16'd0);
      // ch1: RATE=1, two words without reads -> overflow
      pin_in[1] = 1'b0;
      wr(ra(1, 4), 16'd1);
      repeat (3) tick;
      wr(AW'(0), 16'd1);
      repeat (29) tick;
      pin_in[1] = 1'b1;
      repeat (34) tick;
      rd_chk("ovf_status", ra(1, 5), 16'd7);
      rd_chk("ovf_samples", ra(1, 6), 16'hFFFF);
      rd_chk("ovf_clr", ra(1, 5), 16'd1);
      wr(AW'(0), 16'd2);
      rd_chk("ovf_stop", ra(1, 5), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pin_bank_ctrl.md
Name: pin_bank_ctrl

Overview:
- Parametrised multi-channel successor of the single-pin controller. Owns NUM_PINS FPGA pins.
- Each channel is independently configured over the shared register bus as one of: off (hi-Z), PWM generator with cycle count, constant driver, or periodic input sampler with packed sample word and overflow flag.
- Sits between the bus decoder and the top-level tristate pads; pads are split into out/oe/in.

Parameters:
- NUM_PINS, 8, number of channels.
- DATA_W, 16, bus data width; also the width of counters and of the sample word.
- ADDR_W, 21, bus address width.
- GLOBAL_ADDR, 0, address of the global command register.
- BASE_ADDR, 1, address of channel 0 register block. Channel c occupies BASE_ADDR+8*c .. +7.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- addr  in  ADDR_W  register address
- wr_en  in  1  write strobe, one cycle per write
- rd_en  in  1  read strobe, one cycle per read
- data_in  in  DATA_W  write data
- data_out  out  DATA_W  registered read data
- rd_valid  out  1  high exactly one cycle after rd_en
- pin_out  out  NUM_PINS  per-pin drive value
- pin_oe  out  NUM_PINS  per-pin output enable (1 = drive)
- pin_in  in  NUM_PINS  per-pin pad input, asynchronous

Behaviour:
- Reset: all registers, counters, data_out, rd_valid, pin_out and pin_oe are 0. All channels go to IDLE with mode OFF.
- Channel register offsets:
  - 0 CTRL (rw): [1:0] mode: 0 OFF, 1 PWM, 2 CONST, 3 INPUT; [2] const level.
  - 1 DUTY (rw)
  - 2 ANTI (rw)
  - 3 CYCLES (rw): 0 = infinite.
  - 4 RATE (rw)
  - 5 STATUS (ro): [0] busy, [1] sample_valid, [2] overflow.
  - 6 SAMPLES (ro)
  - 7 reserved: reads 0.
- GLOBAL (wo): bit0 START all channels; bit1 STOP all channels. Both bits set in one write: STOP wins.
- Writes to read-only or unmapped addresses are ignored. Unmapped reads return 0.
- Read: data_out and rd_valid update on the clk edge after rd_en (latency 1). data_out holds its value until the next read.
- Read side effects: reading SAMPLES clears sample_valid; reading STATUS clears overflow. Both clears take effect in the same cycle the read data is captured.
- pin_oe[c] = 1 in PWM and CONST modes, 0 in OFF and INPUT modes.
- CONST mode: pin_out[c] = CTRL[2], registered.
- A CTRL write forces the channel to IDLE, clears its counters and applies the new mode on the next cycle.
- PWM FSM states: IDLE, HIGH, LOW.
  - IDLE: pin_out = 0.
  - On START in PWM mode:
    - DUTY = 0 and ANTI = 0: stay IDLE.
    - Else enter HIGH if DUTY != 0, otherwise enter LOW.
    - Load the phase counter from DUTY or ANTI, and clear the cycle counter.
  - HIGH: pin_out = 1 for exactly DUTY clocks, then LOW (ANTI = 0 skips LOW and counts a cycle immediately).
  - LOW: pin_out = 0 for exactly ANTI clocks; at its end the completed-cycle count increments.
    - CYCLES != 0 and count == CYCLES: go to IDLE.
    - Otherwise re-enter HIGH, or LOW again if DUTY = 0.
  - Period = DUTY + ANTI clocks with no gap cycles.
  - DUTY, ANTI and CYCLES are sampled at each phase load, so mid-run writes affect the next phase.
  - busy = 1 outside IDLE.
  - STOP or reset: IDLE on the next edge, pin low.
  - START while busy is ignored.
- INPUT mode:
  - pin_in passes through a 2-flop synchroniser per pin.
  - After START, a sample is taken every RATE+1 clocks; RATE = 0 means every clock. The first sample is taken on the cycle after START.
  - Samples shift into a DATA_W-bit register, MSB first (newest at bit 0).
  - After DATA_W samples, the word moves to SAMPLES, sample_valid is set and the bit counter restarts with no lost sample.
  - Word completes while sample_valid is still 1: SAMPLES is overwritten and overflow is set (sticky).
  - Word completion coinciding with a SAMPLES read: the read returns the old word and valid stays 1 for the new word.
  - busy = 1 while sampling; STOP halts sampling and discards the partial word.
- Counters are DATA_W bits wide; there is no wrap hazard because loads come from DATA_W registers.

Test Plan:
- Reset then read every register of ch0 and ch7 -> all 0, rd_valid one cycle after each rd_en; pin_oe = 0.
- ch2: CTRL=1, DUTY=3, ANTI=2, CYCLES=2, START -> pin_out[2] = 1,1,1,0,0,1,1,1,0,0 then 0; busy falls 10 clocks after the first high cycle; other pins untouched.
- ch0: CYCLES=0, DUTY=1, ANTI=1, START; STOP after 7 clocks -> square wave of period 2, pin low and busy 0 one cycle after STOP; START and STOP in one write -> stays IDLE.
- ch1: CTRL=3, RATE=0, pin_in[1] driven 0xA5C3 bit-serially MSB first -> SAMPLES = 0xA5C3 and sample_valid = 1 after 16 samples (+2 synchroniser cycles); reading SAMPLES clears valid.
- ch1: RATE=1, no reads for 32 samples -> overflow = 1, SAMPLES holds the second word; reading STATUS returns 0b111 then overflow reads 0.
- ch3: CTRL=2 with bit2 = 1 -> pin_out = 1 and pin_oe = 1; then CTRL=0 -> pin_oe = 0 next cycle. Writing DUTY mid-HIGH changes only the following HIGH phase.
